// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Stalls IF/ID for one cycle per load-use pair and counts the bubbles it inserts.
module id_ex_stage #(
  parameter int NB_CONTROL_SIGNALS = 18,
  parameter int NB_DATA            = 32,
  parameter int NB_REG_ADDR        = 5,
  parameter int NB_COUNT           = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic                          i_flush,
  input  logic                          i_clear_count,
  input  logic [NB_CONTROL_SIGNALS-1:0] i_control,
  input  logic [NB_DATA-1:0]            i_rs_data,
  input  logic [NB_DATA-1:0]            i_rt_data,
  input  logic [NB_DATA-1:0]            i_imm,
  input  logic [NB_DATA-1:0]            i_pc_next,
  input  logic [NB_REG_ADDR-1:0]        i_rs,
  input  logic [NB_REG_ADDR-1:0]        i_rt,
  input  logic [NB_REG_ADDR-1:0]        i_rd,
  input  logic [NB_REG_ADDR-1:0]        i_shamt,
  output logic [NB_CONTROL_SIGNALS-1:0] o_control,
  output logic [NB_DATA-1:0]            o_rs_data,
  output logic [NB_DATA-1:0]            o_rt_data,
  output logic [NB_DATA-1:0]            o_imm,
  output logic [NB_DATA-1:0]            o_pc_next,
  output logic [NB_REG_ADDR-1:0]        o_rs,
  output logic [NB_REG_ADDR-1:0]        o_rt,
  output logic [NB_REG_ADDR-1:0]        o_rd,
  output logic [NB_REG_ADDR-1:0]        o_shamt,
  output logic                          o_stall,
  output logic [NB_COUNT-1:0]           o_bubble_count
);

  localparam int MEM_READ_BIT = 15;
  localparam logic [NB_COUNT-1:0] CNT_MAX = '1;

  logic [NB_CONTROL_SIGNALS-1:0] control_q, control_d;
  logic [NB_DATA-1:0]            rs_data_q, rs_data_d;
  logic [NB_DATA-1:0]            rt_data_q, rt_data_d;
  logic [NB_DATA-1:0]            imm_q, imm_d;
  logic [NB_DATA-1:0]            pc_next_q, pc_next_d;
  logic [NB_REG_ADDR-1:0]        rs_q, rs_d;
  logic [NB_REG_ADDR-1:0]        rt_q, rt_d;
  logic [NB_REG_ADDR-1:0]        rd_q, rd_d;
  logic [NB_REG_ADDR-1:0]        shamt_q, shamt_d;
  logic [NB_COUNT-1:0]           count_q, count_d;

  logic hazard;
  logic stall;

  // Both ID sources are compared even if the instruction does not read rt;
  // a spurious bubble costs one cycle, a missed one corrupts data.
  assign hazard = control_q[MEM_READ_BIT] & (rt_q != '0) &
                  ((rt_q == i_rs) | (rt_q == i_rt));
  assign stall  = hazard & ~i_flush;

  always_comb begin
    control_d = control_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc_next_d = pc_next_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    shamt_d   = shamt_q;
    if (i_enable) begin
      // Squashed or bubbled slots carry a zero control word, which is a no-op downstream.
      control_d = (i_flush | hazard) ? '0 : i_control;
      rs_data_d = i_rs_data;
      rt_data_d = i_rt_data;
      imm_d     = i_imm;
      pc_next_d = i_pc_next;
      rs_d      = i_rs;
      rt_d      = i_rt;
      rd_d      = i_rd;
      shamt_d   = i_shamt;
    end
  end

  always_comb begin
    count_d = count_q;
    if (i_clear_count) begin
      count_d = '0;
    end else if (i_enable && stall && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      control_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc_next_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
      count_q   <= '0;
    end else begin
      control_q <= control_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      pc_next_q <= pc_next_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      shamt_q   <= shamt_d;
      count_q   <= count_d;
    end
  end

  assign o_control      = control_q;
  assign o_rs_data      = rs_data_q;
  assign o_rt_data      = rt_data_q;
  assign o_imm          = imm_q;
  assign o_pc_next      = pc_next_q;
  assign o_rs           = rs_q;
  assign o_rt           = rt_q;
  assign o_rd           = rd_q;
  assign o_shamt        = shamt_q;
  assign o_stall        = stall;
  assign o_bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/saturation sequences,
// and random stimulus against a transaction-level model of the EX slot.
module tb_id_ex_stage;

  localparam int NC = 18;
  localparam int ND = 32;
  localparam int NR = 5;

  logic          i_clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_enable = 1'b0, i_flush = 1'b0, i_clear_count = 1'b0;
  logic [NC-1:0] i_control = '0;
  logic [ND-1:0] i_rs_data = '0, i_rt_data = '0, i_imm = '0, i_pc_next = '0;
  logic [NR-1:0] i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;

  logic [NC-1:0] o_control;
  logic [ND-1:0] o_rs_data, o_rt_data, o_imm, o_pc_next;
  logic [NR-1:0] o_rs, o_rt, o_rd, o_shamt;
  logic          o_stall;
  logic [15:0]   o_bubble_count;

  logic [NC-1:0] s_control;
  logic [ND-1:0] s_rs_data, s_rt_data, s_imm, s_pc_next;
  logic [NR-1:0] s_rs, s_rt, s_rd, s_shamt;
  logic          s_stall;
  logic [3:0]    s_bubble_count;

  id_ex_stage u_dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_flush(i_flush),
    .i_clear_count(i_clear_count), .i_control(i_control), .i_rs_data(i_rs_data),
    .i_rt_data(i_rt_data), .i_imm(i_imm), .i_pc_next(i_pc_next), .i_rs(i_rs),
    .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt), .o_control(o_control),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm), .o_pc_next(o_pc_next),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_stall(o_stall),
    .o_bubble_count(o_bubble_count)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  id_ex_stage #(.NB_COUNT(4)) u_sat (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_flush(i_flush),
    .i_clear_count(i_clear_count), .i_control(i_control), .i_rs_data(i_rs_data),
    .i_rt_data(i_rt_data), .i_imm(i_imm), .i_pc_next(i_pc_next), .i_rs(i_rs),
    .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt), .o_control(s_control),
    .o_rs_data(s_rs_data), .o_rt_data(s_rt_data), .o_imm(s_imm), .o_pc_next(s_pc_next),
    .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd), .o_shamt(s_shamt), .o_stall(s_stall),
    .o_bubble_count(s_bubble_count)
  );

  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Model: what instruction currently sits in EX, plus a plain bubble tally.
  typedef struct {
    logic [NC-1:0] ctrl;
    logic [ND-1:0] rsd, rtd, imm, pc;
    logic [NR-1:0] rs, rt, rd, sh;
  } ex_t;
  ex_t m_ex;
  int  m_n;

  function automatic bit m_load_use();
    return m_ex.ctrl[15] && (m_ex.rt != 0) && (m_ex.rt == i_rs || m_ex.rt == i_rt);
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic m_reset();
    m_ex = '{default: '0};
    m_n  = 0;
  endtask

  task automatic m_edge();
    bit lu;
    lu = m_load_use();
    if (i_clear_count) m_n = 0;
    else if (i_enable && lu && !i_flush) m_n++;
    if (i_enable) begin
      m_ex.ctrl = (lu || i_flush) ? '0 : i_control;
      m_ex.rsd = i_rs_data; m_ex.rtd = i_rt_data; m_ex.imm = i_imm; m_ex.pc = i_pc_next;
      m_ex.rs = i_rs; m_ex.rt = i_rt; m_ex.rd = i_rd; m_ex.sh = i_shamt;
    end
  endtask

  task automatic chk_model_outputs();
    chk("ctrl", o_control, m_ex.ctrl);
    chk("rs_data", o_rs_data, m_ex.rsd);
    chk("rt_data", o_rt_data, m_ex.rtd);
    chk("imm", o_imm, m_ex.imm);
    chk("pc_next", o_pc_next, m_ex.pc);
    chk("rs", o_rs, m_ex.rs);
    chk("rt", o_rt, m_ex.rt);
    chk("rd", o_rd, m_ex.rd);
    chk("shamt", o_shamt, m_ex.sh);
    chk("count", o_bubble_count, sat(m_n, 65535));
    chk("sat_count", s_bubble_count, sat(m_n, 15));
  endtask

  // Inputs must already be driven (after a negedge); checks stall, clocks, checks state.
  task automatic model_cycle();
    #1;
    chk("stall", o_stall, m_load_use() && !i_flush);
    @(posedge i_clock);
    m_edge();
    #1;
    chk_model_outputs();
  endtask

  task automatic set_id(input logic en, input logic fl, input logic clr, input logic [NC-1:0] c,
                        input logic [NR-1:0] rs, input logic [NR-1:0] rt, input logic [ND-1:0] rsd);
    i_enable = en; i_flush = fl; i_clear_count = clr; i_control = c;
    i_rs = rs; i_rt = rt; i_rs_data = rsd;
    i_rt_data = rsd ^ 32'hFFFF_0000; i_imm = rsd + 32'd7; i_pc_next = {rsd[29:0], 2'b00};
    i_rd = rs ^ rt; i_shamt = rt + 5'd1;
  endtask

  typedef struct {
    logic en, fl, clr;
    logic [NC-1:0] ctrl;
    logic [NR-1:0] rs, rt;
    logic [ND-1:0] rsd;
    logic          e_stall;
    logic [NC-1:0] e_ctrl;
    logic [ND-1:0] e_rsd;
    logic [15:0]   e_cnt;
  } vec_t;

  localparam logic [NC-1:0] ALU = 18'h00144;
  localparam logic [NC-1:0] LD  = 18'h08100;

  vec_t vt[16];

  initial begin
    vt[0]  = '{1,0,0, ALU, 0,0, 32'h1234, 0, ALU, 32'h1234, 0};
    vt[1]  = '{1,0,0, LD,  0,5, 32'h1,    0, LD,  32'h1,    0};
    vt[2]  = '{1,0,0, ALU, 5,0, 32'h2,    1, 0,   32'h2,    1};
    vt[3]  = '{1,0,0, ALU, 5,0, 32'h3,    0, ALU, 32'h3,    1};
    vt[4]  = '{1,0,0, LD,  0,5, 32'h4,    0, LD,  32'h4,    1};
    vt[5]  = '{1,1,0, ALU, 0,5, 32'h5,    0, 0,   32'h5,    1};
    vt[6]  = '{1,0,0, LD,  0,0, 32'h6,    0, LD,  32'h6,    1};
    vt[7]  = '{1,0,0, ALU, 0,0, 32'h7,    0, ALU, 32'h7,    1};
    vt[8]  = '{1,0,0, LD,  0,3, 32'h8,    0, LD,  32'h8,    1};
    vt[9]  = '{0,0,0, ALU, 3,0, 32'h9,    1, LD,  32'h8,    1};
    vt[10] = '{0,0,0, ALU, 3,0, 32'h9,    1, LD,  32'h8,    1};
    vt[11] = '{0,0,0, ALU, 3,0, 32'h9,    1, LD,  32'h8,    1};
    vt[12] = '{1,0,0, ALU, 3,0, 32'hA,    1, 0,   32'hA,    2};
    vt[13] = '{0,0,1, ALU, 3,0, 32'hB,    0, 0,   32'hA,    0};
    vt[14] = '{1,0,0, LD,  0,3, 32'hE,    0, LD,  32'hE,    0};
    vt[15] = '{1,0,1, ALU, 3,0, 32'hF,    1, 0,   32'hF,    0};

    m_reset();
    #2;
    chk("rst_ctrl", o_control, 0);
    chk("rst_rs_data", o_rs_data, 0);
    chk("rst_count", o_bubble_count, 0);
    chk("rst_stall", o_stall, 0);
    @(negedge i_clock);
    i_reset_n = 1'b1;

    // Directed table
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clock);
      set_id(vt[k].en, vt[k].fl, vt[k].clr, vt[k].ctrl, vt[k].rs, vt[k].rt, vt[k].rsd);
      #1;
      chk($sformatf("v%0d_stall", k), o_stall, vt[k].e_stall);
      @(posedge i_clock);
      m_edge();
      #1;
      chk($sformatf("v%0d_ctrl", k), o_control, vt[k].e_ctrl);
      chk($sformatf("v%0d_rs_data", k), o_rs_data, vt[k].e_rsd);
      chk($sformatf("v%0d_count", k), o_bubble_count, vt[k].e_cnt);
    end

    // Saturation: 20 load-use pairs push the 4-bit copy past its ceiling
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clock);
      set_id(1, 0, 0, LD, 0, 9, k);
      model_cycle();
      @(negedge i_clock);
      set_id(1, 0, 0, ALU, 9, 0, k + 100);
      model_cycle();
    end
    chk("sat_hold", s_bubble_count, 4'hF);
    chk("main_20", o_bubble_count, 16'd20);
    @(negedge i_clock);
    set_id(1, 0, 0, LD, 0, 9, 32'h55);
    model_cycle();
    @(negedge i_clock);
    set_id(1, 0, 1, ALU, 9, 0, 32'h56);
    model_cycle();
    chk("clr_sat", s_bubble_count, 0);

    // Async reset pulse while a stall is pending
    @(negedge i_clock);
    set_id(1, 0, 0, LD, 0, 5, 32'h77);
    model_cycle();
    @(negedge i_clock);
    set_id(1, 1, 1, ALU, 5, 0, 32'h78);
    i_flush = 1'b0; i_clear_count = 1'b0;
    #1;
    chk("pre_rst_stall", o_stall, 1);
    i_reset_n = 1'b0;
    #1;
    chk("arst_ctrl", o_control, 0);
    chk("arst_rt", o_rt, 0);
    chk("arst_stall", o_stall, 0);
    chk("arst_count", o_bubble_count, 0);
    i_reset_n = 1'b1;
    m_reset();
    model_cycle();
    chk("post_rst_ctrl", o_control, ALU);

    // Random stimulus vs model
    for (int k = 0; k < 400; k++) begin
      @(negedge i_clock);
      i_enable      = ($urandom_range(0, 9) < 8);
      i_flush       = ($urandom_range(0, 99) < 15);
      i_clear_count = ($urandom_range(0, 99) < 4);
      i_control     = NC'($urandom);
      i_control[15] = $urandom_range(0, 1);
      i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom; i_pc_next = $urandom;
      i_rs = NR'($urandom_range(0, 3)); i_rt = NR'($urandom_range(0, 3));
      i_rd = NR'($urandom); i_shamt = NR'($urandom);
      model_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter NB_CONTROL_SIGNALS, default 18, width of decoded control word.
REQ-002 Parameter NB_DATA, default 32, width of register operands, immediate and PC.
REQ-003 Parameter NB_REG_ADDR, default 5, register-index width.
REQ-004 Parameter NB_COUNT, default 16, width of hazard-bubble counter.
REQ-005 i_clock  input  1  single clock; all state updates on rising edge.
REQ-006 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_enable  input  1  pipeline advance enable from debug unit (step/continuous); 0 = hold.
REQ-008 i_flush  input  1  branch/jump taken in ID; squash instruction entering EX.
REQ-009 i_clear_count  input  1  synchronous clear of bubble counter.
REQ-010 i_control  input  NB_CONTROL_SIGNALS  decoded control word; bit15 MemRead, bit13 MemWrite, bit8 RegWrite.
REQ-011 i_rs_data, i_rt_data  input  NB_DATA each  register-file read data.
REQ-012 i_imm  input  NB_DATA  extended immediate.
REQ-013 i_pc_next  input  NB_DATA  PC+4 of ID instruction.
REQ-014 i_rs, i_rt, i_rd, i_shamt  input  NB_REG_ADDR each  instruction fields.
REQ-015 o_control, o_rs_data, o_rt_data, o_imm, o_pc_next, o_rs, o_rt, o_rd, o_shamt  output  same widths  registered EX-stage copies.
REQ-016 o_stall  output  1  load-use hazard; freezes PC and IF/ID, forces decoder enable off.
REQ-017 o_bubble_count  output  NB_COUNT  number of hazard bubbles inserted.

Function
REQ-018 Hazard = o_control[15] & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt)); both sources compared unconditionally (conservative).
REQ-019 o_stall SHALL be combinational: hazard & ~i_flush (flush discards ID instruction; no stall needed).
REQ-020 i_enable=0: every register, including counter, holds; o_stall still reflects held state.
REQ-021 i_enable=1, i_flush=1: o_control <= 0; other fields latch inputs; counter unchanged.
REQ-022 i_enable=1, i_flush=0, hazard=1: o_control <= 0 (bubble); other fields latch inputs; counter increments.
REQ-023 i_enable=1, i_flush=0, hazard=0: all outputs latch inputs; latency one cycle.
REQ-024 Bubble clears o_control[15], so hazard self-terminates after exactly one stall cycle for a single load.
REQ-025 Counter saturates at 2^NB_COUNT-1; no wrap.
REQ-026 i_clear_count=1 on edge: counter <= 0 regardless of i_enable; clear has priority over simultaneous increment.
REQ-027 Register $0 as load target never raises hazard.
REQ-028 Zero control word SHALL have no architectural effect downstream (no write, no memory access, no branch).

Reset
REQ-029 i_reset_n=0 asynchronously forces all registered outputs and o_bubble_count to 0; o_stall therefore 0.
REQ-030 Reset deassertion mid-stall: first post-reset edge treats stage as empty; no residual bubble.
REQ-031 Reset dominates i_enable, i_flush, i_clear_count.

Verification
REQ-032 Reset then enable=1, i_control=18'h00144, i_rs_data=32'h1234 -> next edge o_control=18'h00144, o_rs_data=32'h1234, o_stall=0.
REQ-033 Load latched (o_control[15]=1, o_rt=5), ID i_rs=5 -> o_stall=1; next edge o_control=0, o_bubble_count=1; following cycle o_stall=0.
REQ-034 Same load, i_rt=5 and i_flush=1 -> o_stall=0, next o_control=0, counter unchanged.
REQ-035 Load with o_rt=0, i_rs=0 -> o_stall=0, no bubble; enable=0 for 3 cycles with hazard pending -> outputs and counter frozen.
REQ-036 Counter preset to 16'hFFFF via repeated hazards -> further hazard leaves 16'hFFFF; i_clear_count with hazard -> 0.
REQ-037 i_reset_n pulsed low between edges during stall -> outputs 0 immediately, o_stall=0.
